// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and types for the S/PDIF transmitter.
//   PRE_B/PRE_M/PRE_W : 8 half-cell preamble patterns, first half-cell in bit 7
//   SLOT_V..SLOT_P    : slot indices of the validity/user/status/parity bits
//   FRAMES_PER_BLOCK  : channel-status block length
//   state_e           : transmit FSM states
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [4:0] SLOT_V = 5'd28;
    localparam logic [4:0] SLOT_U = 5'd29;
    localparam logic [4:0] SLOT_C = 5'd30;
    localparam logic [4:0] SLOT_P = 5'd31;

    localparam int unsigned FRAMES_PER_BLOCK = 192;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        BODY
    } state_e;

endpackage

// File: rtl/spdif_fifo.sv
// spdif_fifo: synchronous FIFO holding sample pairs for the S/PDIF transmitter.
//   clk, rst     : clock, asynchronous active-low reset (contents discarded)
//   push_i       : write wdata_i when not full
//   pop_i        : advance read pointer when not empty
//   rdata_o      : head entry (valid while !empty_o)
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
module spdif_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spdif_tx.sv
// spdif_tx: IEC 60958 consumer (S/PDIF) transmitter with biphase-mark output.
//   clk, rst    : system clock, asynchronous active-low reset
//   en          : transmit enable; stream stops after a full frame once low
//   audio_l/r   : PCM sample pair, two's complement, MSB-aligned into 24 bits
//   audio_valid : pair present; accepted when audio_rdy is high
//   audio_rdy   : FIFO can accept a pair (en & !full)
//   spdif_out   : registered biphase-mark line output
//   block_start : one-cycle pulse when the frame 0 B preamble begins
//   underrun    : one-cycle pulse when a frame starts with the FIFO empty
// Build option: SPDIF_TX_UNDERRUN_REPEAT_EN resends the previous pair (V=1)
// on underrun instead of zeros.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [31:0] CS_WORD  = 32'h0000_0004,
    parameter bit          MONO     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    input  logic                audio_valid,
    output logic                audio_rdy,
    output logic                spdif_out,
    output logic                block_start,
    output logic                underrun
);

    localparam int unsigned DW = $clog2(CLK_DIV);

    state_e              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [5:0]          hc_q, hc_d;
    logic                sub_q, sub_d;
    logic [7:0]          frame_q, frame_d;
    logic                lvl_q, lvl_d;
    logic                base_q, base_d;
    logic                bs_q, bs_d;
    logic                ur_q, ur_d;
    logic                run_q;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic                hold_v_q, hold_v_d;

    logic                tick, entry, pop;
    logic                fifo_full, fifo_empty;
    logic [2*SAMPLE_W-1:0] fifo_rdata;
    logic [7:0]          pre_pat;
    logic [23:0]         field;
    logic [4:0]          slot, sidx;
    logic                cbit, slot_bit;

    // run_q keeps audio_rdy low during reset and for the first cycle after it
    assign audio_rdy   = en & ~fifo_full & run_q;
    assign spdif_out   = lvl_q;
    assign block_start = bs_q;
    assign underrun    = ur_q;

    assign tick = (div_q == DW'(CLK_DIV - 1));

    spdif_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (audio_valid & audio_rdy),
        .wdata_i ({audio_l, (MONO ? audio_l : audio_r)}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state: counters advance once per half-cell tick
    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        state_d = state_q;
        hc_d    = hc_q;
        sub_d   = sub_q;
        frame_d = frame_q;
        entry   = 1'b0;
        if (state_q == IDLE && !en) div_d = '0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = PRE;
                        hc_d    = '0;
                        sub_d   = 1'b0;
                        frame_d = '0;
                        entry   = 1'b1;
                    end
                end
                default: begin
                    if (hc_q == 6'd63) begin
                        hc_d = '0;
                        if (!en && sub_q) begin
                            state_d = IDLE;
                            sub_d   = 1'b0;
                            frame_d = '0;
                        end else begin
                            state_d = PRE;
                            sub_d   = ~sub_q;
                            entry   = 1'b1;
                            if (sub_q)
                                frame_d = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? '0 : frame_q + 1'b1;
                        end
                    end else begin
                        hc_d    = hc_q + 1'b1;
                        state_d = (hc_q >= 6'd7) ? BODY : PRE;
                    end
                end
            endcase
        end
    end

    // Datapath: pair pop, preamble/slot bit selection and biphase-mark level
    always_comb begin
        pop      = entry & ~sub_d;
        bs_d     = pop & (frame_d == '0);
        ur_d     = pop & fifo_empty;
        base_d   = entry ? lvl_q : base_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        hold_v_d = hold_v_q;
        if (pop) begin
            if (!fifo_empty) begin
                {hold_l_d, hold_r_d} = fifo_rdata;
                hold_v_d = 1'b0;
            end else begin
                hold_v_d = 1'b1;
`ifdef SPDIF_TX_UNDERRUN_REPEAT_EN
                hold_l_d = hold_l_q;
                hold_r_d = hold_r_q;
`else
                hold_l_d = '0;
                hold_r_d = '0;
`endif
            end
        end

        pre_pat = sub_d ? PRE_W : ((frame_d == '0) ? PRE_B : PRE_M);

        // Body half-cells never change sub/frame, so the _q copies describe them
        field = '0;
        field[23 -: SAMPLE_W] = sub_q ? hold_r_q : hold_l_q;
        cbit  = (frame_q < 8'd32) ? CS_WORD[frame_q[4:0]] : 1'b0;
        slot  = hc_d[5:1];
        sidx  = slot - 5'd4;
        case (slot)
            SLOT_V:  slot_bit = hold_v_q;
            SLOT_U:  slot_bit = 1'b0;
            SLOT_C:  slot_bit = cbit;
            SLOT_P:  slot_bit = (^field) ^ hold_v_q ^ cbit;
            default: slot_bit = (sidx < 5'd24) ? field[sidx] : 1'b0;
        endcase

        // Preamble is referenced to the level at entry; data toggles every slot
        lvl_d = lvl_q;
        if (tick) begin
            if (state_d == IDLE)
                lvl_d = 1'b0;
            else if (state_d == PRE)
                lvl_d = pre_pat[~hc_d[2:0]] ^ (entry ? lvl_q : base_q);
            else if (!hc_d[0])
                lvl_d = ~lvl_q;
            else
                lvl_d = lvl_q ^ slot_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            hc_q     <= '0;
            sub_q    <= 1'b0;
            frame_q  <= '0;
            lvl_q    <= 1'b0;
            base_q   <= 1'b0;
            bs_q     <= 1'b0;
            ur_q     <= 1'b0;
            run_q    <= 1'b0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            hold_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            hc_q     <= hc_d;
            sub_q    <= sub_d;
            frame_q  <= frame_d;
            lvl_q    <= lvl_d;
            base_q   <= base_d;
            bs_q     <= bs_d;
            ur_q     <= ur_d;
            run_q    <= 1'b1;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            hold_v_q <= hold_v_d;
        end
    end

endmodule

// File: tb/tb_spdif_tx.sv
// tb_spdif_tx: directed bench for spdif_tx. A stereo instance (CLK_DIV=2) and
// a mono instance (CLK_DIV=4) share clock and reset; the line output is
// sampled once per half-cell and decoded back into preamble and slot bits.
module tb_spdif_tx;

    localparam int unsigned CD  = 2;
    localparam int unsigned CDM = 4;
    localparam int unsigned FC  = 128 * CD;

`ifdef SPDIF_TX_UNDERRUN_REPEAT_EN
    localparam logic [23:0] UR_A = 24'h800100;
    localparam logic [23:0] UR_B = 24'h000100;
`else
    localparam logic [23:0] UR_A = 24'h000000;
    localparam logic [23:0] UR_B = 24'h000000;
`endif

    typedef struct packed {
        logic [7:0]  pre;
        logic [23:0] data;
        logic        v;
        logic        u;
        logic        c;
        logic        par_ok;
        logic        bmc_ok;
    } sf_t;

    logic        clk = 1'b0;
    logic        rst, en, valid, rdy, sout, bs, ur;
    logic [15:0] l, r;
    logic        en_m, valid_m, rdy_m, sout_m, bs_m, ur_m;
    logic [15:0] l_m, r_m;

    int unsigned n_chk = 0, n_err = 0;
    int unsigned cyc = 0, acc = 0, ur_cnt = 0, last_bs = 0, bs_period = 0, bs_seen = 0;
    logic        prev_lvl;

    always #5 clk = ~clk;

    spdif_tx #(
        .SAMPLE_W (16), .DEPTH (8), .CLK_DIV (CD), .CS_WORD (32'h0000_0004), .MONO (1'b0)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .audio_l (l), .audio_r (r),
        .audio_valid (valid), .audio_rdy (rdy), .spdif_out (sout),
        .block_start (bs), .underrun (ur)
    );

    spdif_tx #(
        .SAMPLE_W (16), .DEPTH (8), .CLK_DIV (CDM), .CS_WORD (32'h0000_0004), .MONO (1'b1)
    ) dut_m (
        .clk (clk), .rst (rst), .en (en_m), .audio_l (l_m), .audio_r (r_m),
        .audio_valid (valid_m), .audio_rdy (rdy_m), .spdif_out (sout_m),
        .block_start (bs_m), .underrun (ur_m)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid && rdy) acc <= acc + 1;
        if (ur) ur_cnt <= ur_cnt + 1;
        if (bs) begin
            if (bs_seen != 0) bs_period <= cyc - last_bs;
            last_bs <= cyc;
            bs_seen <= bs_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first cycle with block_start high
    task automatic wait_bs(input bit m, input int unsigned limit);
        logic found = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m ? bs_m : bs) begin
                found = 1'b1;
                break;
            end
            prev_lvl = m ? sout_m : sout;
        end
        check(m ? "wait_bs_mono" : "wait_bs", found, 1);
    endtask

    // Returns at the negedge of the first cycle of the next frame (stereo DUT)
    task automatic wait_fs(input int unsigned limit);
        logic found = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bs || (bs_seen != 0 && ((cyc - last_bs) % FC) == 0)) begin
                found = 1'b1;
                break;
            end
            prev_lvl = sout;
        end
        check("wait_frame", found, 1);
    endtask

    task automatic capture(input bit m, output logic [127:0] h);
        for (int i = 0; i < 128; i++) begin
            h[i] = m ? sout_m : sout;
            repeat (m ? CDM : CD) @(negedge clk);
        end
    endtask

    function automatic sf_t decode(input logic [127:0] h, input int unsigned s, input logic prev);
        sf_t         d;
        logic [31:0] b;
        int unsigned o;
        logic        p0;
        o = 64 * s;
        p0 = (s == 0) ? prev : h[63];
        b = '0;
        d = '0;
        for (int i = 0; i < 8; i++) d.pre[7-i] = h[o+i] ^ p0;
        d.bmc_ok = 1'b1;
        for (int k = 4; k < 32; k++) begin
            b[k] = h[o+2*k] ^ h[o+2*k+1];
            if (h[o+2*k] == h[o+2*k-1]) d.bmc_ok = 1'b0;
        end
        d.data   = b[27:4];
        d.v      = b[28];
        d.u      = b[29];
        d.c      = b[30];
        d.par_ok = ~^b[31:4];
        return d;
    endfunction

    task automatic check_sf(input string tag, input sf_t d, input logic [7:0] pre,
                            input logic [23:0] data, input logic v, input logic c);
        check({tag, ".pre"}, d.pre, pre);
        check({tag, ".data"}, d.data, data);
        check({tag, ".v"}, d.v, v);
        check({tag, ".u"}, d.u, 0);
        check({tag, ".c"}, d.c, c);
        check({tag, ".par"}, d.par_ok, 1);
        check({tag, ".bmc"}, d.bmc_ok, 1);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] h;
        sf_t          da, db;
        int unsigned  u0, a0;
        logic         found;

        rst = 1'b0; en = 1'b1; valid = 1'b0; l = '0; r = '0;
        en_m = 1'b0; valid_m = 1'b0; l_m = '0; r_m = '0;
        prev_lvl = 1'b0;

        // Reset state, with en high
        repeat (3) @(negedge clk);
        check("rst.spdif", sout, 0);
        check("rst.rdy", rdy, 0);
        check("rst.bs", bs, 0);
        check("rst.ur", ur, 0);
        en = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.spdif", sout, 0);
        check("idle.rdy_en0", rdy, 0);

        // First pair ahead of the first frame
        en = 1'b1; l = 16'h8001; r = 16'h0001; valid = 1'b1;
        #1 check("rdy_en1", rdy, 1);
        @(negedge clk);
        valid = 1'b0;
        wait_bs(0, 20);
        check("f0.ur", ur, 0);
        capture(0, h);
        da = decode(h, 0, prev_lvl);
        db = decode(h, 1, prev_lvl);
        prev_lvl = h[127];
        check_sf("f0A", da, 8'hE8, 24'h800100, 1'b0, 1'b0);
        check_sf("f0B", db, 8'hE4, 24'h000100, 1'b0, 1'b0);

        // Three frames with nothing written
        u0 = ur_cnt;
        for (int f = 1; f <= 3; f++) begin
            capture(0, h);
            da = decode(h, 0, prev_lvl);
            db = decode(h, 1, prev_lvl);
            prev_lvl = h[127];
            check_sf($sformatf("f%0dA", f), da, 8'hE2, UR_A, 1'b1, f == 2);
            check_sf($sformatf("f%0dB", f), db, 8'hE4, UR_B, 1'b1, f == 2);
        end
        check("underruns", ur_cnt - u0, 3);

        // Fill the FIFO with valid held high, then one pop frees one slot
        a0 = acc;
        valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            l = 16'h1000 + 16'(acc - a0);
            r = 16'h2000 + 16'(acc - a0);
            @(negedge clk);
        end
        check("fill.count", acc - a0, 8);
        check("fill.rdy", rdy, 0);
        wait_fs(FC + 8);
        capture(0, h);
        valid = 1'b0;
        check("refill.count", acc - a0, 9);
        da = decode(h, 0, prev_lvl);
        db = decode(h, 1, prev_lvl);
        prev_lvl = h[127];
        check_sf("f5A", da, 8'hE2, 24'h100000, 1'b0, 1'b0);
        check_sf("f5B", db, 8'hE4, 24'h200000, 1'b0, 1'b0);

        // Next block: B only in frame 0, period of one block
        wait_bs(0, 60000);
        capture(0, h);
        da = decode(h, 0, prev_lvl);
        db = decode(h, 1, prev_lvl);
        prev_lvl = h[127];
        check("b2f0A.pre", da.pre, 8'hE8);
        check("b2f0B.pre", db.pre, 8'hE4);
        capture(0, h);
        da = decode(h, 0, prev_lvl);
        prev_lvl = h[127];
        check("b2f1A.pre", da.pre, 8'hE2);
        check("bs.period", bs_period, 192 * 128 * CD);
        check("bs.count", bs_seen, 2);

        // Reset mid-subframe with a pair waiting in the FIFO
        valid = 1'b1; l = 16'hAAAA; r = 16'h5555;
        @(negedge clk);
        valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sout) begin
                found = 1'b1;
                break;
            end
        end
        check("mid.line_high", found, 1);
        rst = 1'b0;
        #1;
        check("mid.spdif", sout, 0);
        check("mid.rdy", rdy, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        en = 1'b1;
        wait_bs(0, 20);
        check("post.ur", ur, 1);
        capture(0, h);
        da = decode(h, 0, prev_lvl);
        db = decode(h, 1, prev_lvl);
        check_sf("postA", da, 8'hE8, 24'h000000, 1'b1, 1'b0);
        check_sf("postB", db, 8'hE4, 24'h000000, 1'b1, 1'b0);
        en = 1'b0;

        // Mono instance: left sample in both subframes
        en_m = 1'b1; l_m = 16'h1234; r_m = 16'hFFFF; valid_m = 1'b1;
        #1 check("mono.rdy", rdy_m, 1);
        @(negedge clk);
        valid_m = 1'b0;
        prev_lvl = 1'b0;
        wait_bs(1, 40);
        capture(1, h);
        da = decode(h, 0, prev_lvl);
        db = decode(h, 1, prev_lvl);
        check_sf("monoA", da, 8'hE8, 24'h123400, 1'b0, 1'b0);
        check_sf("monoB", db, 8'hE4, 24'h123400, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spdif_tx.md
# spdif_tx

Parametrised S/PDIF (IEC 60958 consumer) transmitter, the successor to the fixed 16-bit audio path feeding HDMI_SPDIF in the HDMI top level. It accepts stereo or mono PCM samples of configurable width through a valid/ready handshake into an internal FIFO. It emits a biphase-mark encoded stream with B/M/W preambles, parity, channel-status and validity bits, and 192-frame block framing. The bit rate is set by an integer divider from the system clock.

## Interface
- SAMPLE_W, 16, audio sample width, 16..24; MSB-aligned into the 24-bit slot field, unused LSB slots sent as 0
- DEPTH, 8, FIFO depth in stereo pairs; power of 2, >= 2
- CLK_DIV, 4, clk cycles per biphase half-cell, >= 2
- CS_WORD, 32'h0000_0004, channel-status bits 0..31; bits 32..191 sent as 0
- MONO, 0, 1 = audio_l sent in both subframes, audio_r ignored
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- en  in  1  transmit enable (HDMI config-done)
- audio_l  in  SAMPLE_W  left / mono sample, two's complement
- audio_r  in  SAMPLE_W  right sample
- audio_valid  in  1  sample pair present
- audio_rdy  out  1  FIFO can accept a pair
- spdif_out  out  1  encoded line output
- block_start  out  1  one-cycle pulse when frame 0 preamble (B) begins
- underrun  out  1  one-cycle pulse when a frame starts with FIFO empty

## Operation
- Reset values: spdif_out=0, audio_rdy=0, block_start=0, underrun=0; FIFO empty, counters 0, line level 0.
- audio_rdy = en & !full. A pair is written on audio_valid & audio_rdy. audio_valid with audio_rdy low is ignored.
- Counters: div (0..CLK_DIV-1), hc half-cell in subframe (0..63), sub (0=A, 1=B), frame (0..191). tick = div==CLK_DIV-1. All counters wrap.
- FSM: IDLE -> PRE on first tick with en=1 (hc=0, sub=0, frame=0). PRE lasts hc 0..7 and then goes to BODY. BODY lasts hc 8..63: at hc=63 go to PRE, or to IDLE if en=0 and sub=1.
- IDLE: spdif_out held 0, counters cleared, FIFO retained.
- Frame pop: at PRE entry with sub=0, pop one pair into a holding register. If the FIFO is empty, load zeros, set V=1 for both subframes and pulse underrun.
- Preambles: B (sub 0, frame 0) = 11101000, M (sub 0, other frames) = 11100010, W (sub 1) = 11100100. The pattern is XORed with the current line level.
- Slots 4..27 carry the sample LSB first; slot 27 = sample MSB. Slot 28 = V, slot 29 = U = 0, slot 30 = C = CS_WORD[frame] (0 if frame >= 32). Slot 31 = P, chosen so slots 4..31 hold an even number of ones.
- Biphase mark: the level toggles at every slot start, and toggles again at mid-slot if the bit is 1.
- block_start pulses the cycle PRE is entered with frame=0, sub=0.
- Simultaneous write and pop on a full FIFO: the pop frees space first, and audio_rdy rises the next cycle only.
- Reset mid-stream: immediate return to reset values; the FIFO contents are discarded.

## Timing
- spdif_out is registered and changes one cycle after a tick. Each half-cell is exactly CLK_DIV cycles.
- Frame = 128 half-cells = 128*CLK_DIV cycles.
- Write-to-line latency: a pair written into an empty FIFO is transmitted at the next sub=0 PRE entry. The maximum is one frame plus 2 cycles.
- audio_rdy falls the cycle after the write that fills the FIFO.

## Configuration
- SPDIF_TX_UNDERRUN_REPEAT_EN defined: on underrun, resend the previous holding-register pair with V=1. After reset the holding register is zero.
- Not defined: on underrun, send zeros with V=1.
- underrun pulses identically in both cases.

## Structure
- Package spdif_pkg holds: preamble constants PRE_B/PRE_M/PRE_W (8-bit), slot indices (SLOT_V=28, SLOT_U=29, SLOT_C=30, SLOT_P=31), FRAMES_PER_BLOCK=192, and the FSM state enum {IDLE, PRE, BODY}.
- Sub-module spdif_fifo is a synchronous FIFO of width 2*SAMPLE_W (DEPTH, full/empty, push/pop), reset with the same rst.

## Test plan
- Reset, en=1, CLK_DIV=4, write L=16'h8001, R=16'h0001 -> first subframe has preamble B. Slots 4..11 are 0 and slots 12..27 are 1000000000000001 LSB-first. Parity is correct and V=0.
- Write nothing for 3 frames -> underrun pulses 3 times and V=1. Payload is zeros, or the previous pair when SPDIF_TX_UNDERRUN_REPEAT_EN is defined.
- Stream 400 frames -> block_start pulses every 128*4*192 = 98304 cycles. Only frame 0 uses B, and C follows CS_WORD bit 2 = 1 in frame 2.
- DEPTH=8, en=1, hold audio_valid high with no pops yet -> 8 writes accepted, then audio_rdy=0. After one pop, exactly one more write is accepted.
- MONO=1, L=16'h1234, R=16'hFFFF -> both subframes carry 16'h1234.
- Assert rst low mid-subframe -> spdif_out=0 and audio_rdy=0 immediately. After release, the FIFO is empty and the first frame underruns.
